// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score binary-to-BCD converter:
//   state_e     - converter FSM state encoding
//   MAX_SCORE   - largest score shown on four BCD digits
//   BCD_DIGITS  - number of displayed BCD digits
//   BLANK_ZERO  - blank mask shown for a value of zero (ones digit stays lit)
//   BCD_SAT     - display pattern for a saturated result
//   blank_mask  - leading-zero blank mask for a group of displayed digits
// -----------------------------------------------------------------------------
package score_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned MAX_SCORE  = 9999;
    localparam int unsigned BCD_DIGITS = 4;

    localparam logic [BCD_DIGITS-1:0]   BLANK_ZERO = 4'b1110;
    localparam logic [4*BCD_DIGITS-1:0] BCD_SAT    = 16'h9999;

    // Digit n (n >= 1) is blanked when it and every digit above it are zero.
    // The ones digit is never blanked, so zero still shows a single '0'.
    function automatic logic [BCD_DIGITS-1:0] blank_mask(
        input logic [4*BCD_DIGITS-1:0] digits
    );
        logic [BCD_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int n = BCD_DIGITS - 1; n >= 1; n--) begin
            all_zero = all_zero & (digits[4*n +: 4] == 4'd0);
            mask[n]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next digit.
// Purely combinational.
// Ports:
//   i_digit  in  4  BCD digit before correction
//   o_digit  out 4  corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Digits reaching this block are at most 9, so the sum fits in 4 bits.
    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/score_bcd_conv.sv
// -----------------------------------------------------------------------------
// score_bcd_conv
// Sequential binary-to-BCD converter (shift-and-add-3) for a game score feeding
// a four-digit 7-segment controller. One conversion takes WIDTH shift cycles
// plus one cycle to register the result.
//
// Build option:
//   SCORE_SATURATE_EN  defined   -> scores above 9999 display 9999, no blanking
//                      undefined -> scores above 9999 display score mod 10000
//   The overflow flag is identical in both builds.
//
// Ports:
//   clk       in   1      clock, all state on rising edge
//   clr       in   1      synchronous active-high reset, aborts any conversion
//   start     in   1      start a conversion (only honoured when idle)
//   score     in   WIDTH  unsigned binary score
//   busy      out  1      conversion in progress
//   valid     out  1      one-cycle pulse when bcd/blank/overflow update
//   bcd       out  16     four BCD digits, [15:12] thousands .. [3:0] ones
//   blank     out  4      leading-zero blank mask, bit n = digit n
//   overflow  out  1      last converted score exceeded 9999
// -----------------------------------------------------------------------------
module score_bcd_conv
    import score_pkg::*;
#(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] score,
    output logic             busy,
    output logic             valid,
    output logic [15:0]      bcd,
    output logic [3:0]       blank,
    output logic             overflow
);

    // Five accumulator digits cover any score up to 99999 (WIDTH <= 16).
    localparam int unsigned ACC_DIGITS = BCD_DIGITS + 1;
    localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
    localparam int unsigned CNT_W      = $clog2(WIDTH + 1);
    localparam int unsigned CAT_W      = ACC_W + WIDTH;

    state_e             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_valid;
    logic [15:0]        r_bcd;
    logic [3:0]         r_blank;
    logic               r_overflow;

    logic [ACC_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat;
    logic [CAT_W-1:0]   w_next;
    logic               w_ovf;
    logic [15:0]        w_low;
    logic [15:0]        w_res_bcd;
    logic [3:0]         w_res_blank;
    logic               w_last;

    // Per-digit add-3 correction applied before each shift.
    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // {accumulator, binary} shifted left as one register; the binary MSB
    // moves into the accumulator LSB.
    assign w_cat  = {w_adj, r_bin};
    assign w_next = w_cat << 1;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Result formatting from the finished accumulator.
    assign w_ovf = (r_acc[ACC_W-1 -: 4] != 4'd0);
    assign w_low = r_acc[15:0];

`ifdef SCORE_SATURATE_EN
    assign w_res_bcd   = w_ovf ? BCD_SAT : w_low;
    assign w_res_blank = w_ovf ? 4'b0000 : blank_mask(w_low);
`else
    assign w_res_bcd   = w_low;
    assign w_res_blank = blank_mask(w_low);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= StIdle;
            r_bin      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_bcd      <= 16'h0000;
            r_blank    <= BLANK_ZERO;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_bin   <= score;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_acc <= w_next[WIDTH +: ACC_W];
                    r_bin <= w_next[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_bcd      <= w_res_bcd;
                    r_blank    <= w_res_blank;
                    r_overflow <= w_ovf;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_conv
// Self-checking bench for score_bcd_conv. Expected results come from a decimal
// arithmetic model of the display (digits via / and %, blanking via magnitude).
// Honours SCORE_SATURATE_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_score_bcd_conv;

    localparam int W   = 14;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] score;
    logic         busy;
    logic         valid;
    logic [15:0]  bcd;
    logic [3:0]   blank;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_bcd_conv #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .score    (score),
        .busy     (busy),
        .valid    (valid),
        .bcd      (bcd),
        .blank    (blank),
        .overflow (overflow)
    );

    // Reference: what the display should show for a given score.
    function automatic logic [20:0] model(input int s);
        int         low;
        logic       eo;
        logic [15:0] eb;
        logic [3:0]  ebl;
        eo  = (s > 9999);
        low = s % 10000;
        eb  = {4'(low / 1000), 4'((low / 100) % 10), 4'((low / 10) % 10), 4'(low % 10)};
        ebl = 4'b0000;
        if (low < 1000) ebl[3] = 1'b1;
        if (low < 100)  ebl[2] = 1'b1;
        if (low < 10)   ebl[1] = 1'b1;
`ifdef SCORE_SATURATE_EN
        if (eo) begin
            eb  = 16'h9999;
            ebl = 4'b0000;
        end
`endif
        return {eb, ebl, eo};
    endfunction

    // Launch one conversion and wait (bounded) for valid. lat counts rising
    // edges after the edge that sampled start.
    task automatic run_conv(input int s, output int lat);
        start = 1'b1;
        score = W'(s);
        @(negedge clk);
        start = 1'b0;
        score = W'($urandom);
        lat   = 0;
        while (valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        clr   = 1'b1;
        start = 1'b1;
        score = W'(123);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, valid, bcd, blank, overflow} !== {1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b valid=%b bcd=%h blank=%b ovf=%b exp 0 0 0000 1110 0",
                     busy, valid, bcd, blank, overflow);
        end
        clr   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_vectors();
        int          vec[11] = '{0, 2048, 7, 12345, 16383, 9999, 10000, 10005, 1, 100, 2048};
        int          lat;
        logic [20:0] exp;
        for (int i = 0; i < 11; i++) begin
            exp = model(vec[i]);
            run_conv(vec[i], lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL vec_latency score=%0d got %0d exp %0d", vec[i], lat, LAT);
            end
            checks++;
            if ({bcd, blank, overflow} !== exp) begin
                errors++;
                $display("FAIL vec_result score=%0d got bcd=%h blank=%b ovf=%b exp bcd=%h blank=%b ovf=%b",
                         vec[i], bcd, blank, overflow, exp[20:5], exp[4:1], exp[0]);
            end
            @(negedge clk);
            checks++;
            if ({valid, bcd, blank, overflow} !== {1'b0, exp}) begin
                errors++;
                $display("FAIL vec_hold score=%0d got valid=%b bcd=%h blank=%b ovf=%b exp valid=0 bcd=%h",
                         vec[i], valid, bcd, blank, overflow, exp[20:5]);
            end
        end
    endtask

    task automatic test_random();
        int          s;
        int          lat;
        logic [20:0] exp;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            s   = $urandom_range(0, 16383);
            exp = model(s);
            run_conv(s, lat);
            checks++;
            if (lat !== LAT || {bcd, blank, overflow} !== exp) begin
                errors++;
                $display("FAIL random score=%0d got lat=%0d bcd=%h blank=%b ovf=%b exp lat=%0d bcd=%h blank=%b ovf=%b",
                         s, lat, bcd, blank, overflow, LAT, exp[20:5], exp[4:1], exp[0]);
            end
        end
    endtask

    // Starts issued in the valid cycle itself, with no idle gap.
    task automatic test_back_to_back();
        int          vec[4] = '{9, 10, 99, 16000};
        int          lat;
        logic [20:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = model(vec[i]);
            run_conv(vec[i], lat);
            checks++;
            if (lat !== LAT || {bcd, blank, overflow} !== exp) begin
                errors++;
                $display("FAIL back_to_back score=%0d got lat=%0d bcd=%h blank=%b ovf=%b exp lat=%0d bcd=%h blank=%b ovf=%b",
                         vec[i], lat, bcd, blank, overflow, LAT, exp[20:5], exp[4:1], exp[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int          pulses   = 0;
        int          busy_bad = 0;
        int          first_lat = -1;
        logic [15:0] first_bcd = 16'hxxxx;
        start = 1'b1;
        score = W'(512);
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1;
                score = W'(64);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (valid === 1'b1) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat = c;
                    first_bcd = bcd;
                end
            end else if (first_lat < 0 && busy !== 1'b1) begin
                busy_bad++;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (first_lat !== LAT || first_bcd !== 16'h0512) begin
            errors++;
            $display("FAIL ignore_start_result got lat=%0d bcd=%h exp lat=%0d bcd=0512",
                     first_lat, first_bcd, LAT);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL ignore_start_busy got %0d low cycles exp 0", busy_bad);
        end
    endtask

    task automatic test_clr_abort();
        int          pulses = 0;
        int          busy_hi = 0;
        int          lat;
        logic [20:0] exp;
        start = 1'b1;
        score = W'(9999);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        clr   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, valid, bcd, blank, overflow} !== {1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0}) begin
            errors++;
            $display("FAIL clr_abort_state got busy=%b valid=%b bcd=%h blank=%b ovf=%b exp 0 0 0000 1110 0",
                     busy, valid, bcd, blank, overflow);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++;
        if (pulses !== 0 || busy_hi !== 0) begin
            errors++;
            $display("FAIL clr_abort_quiet got pulses=%0d busy_cycles=%0d exp 0 0", pulses, busy_hi);
        end
        exp = model(30);
        run_conv(30, lat);
        checks++;
        if (lat !== LAT || {bcd, blank, overflow} !== exp
            || {bcd, blank} !== {16'h0030, 4'b1100}) begin
            errors++;
            $display("FAIL clr_then_30 got lat=%0d bcd=%h blank=%b ovf=%b exp lat=%0d bcd=0030 blank=1100 ovf=0",
                     lat, bcd, blank, overflow, LAT);
        end
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        score = '0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_clr_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
